// File: rtl/core_seq_pkg.sv
// Shared types and constants for the UART transaction sequencer.
package core_seq_pkg;

    // 11 states in a 4-bit encoding
    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLdAm  = 4'd1,
        StLdAl  = 4'd2,
        StLdBm  = 4'd3,
        StLdBl  = 4'd4,
        StExe   = 4'd5,
        StWaitC = 4'd6,
        StSendM = 4'd7,
        StWaitM = 4'd8,
        StSendL = 4'd9,
        StWaitL = 4'd10
    } seq_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RXGAP = 2'b01;
    localparam logic [1:0] ERR_ALU   = 2'b10;

    // Successor of a byte-load state once its byte has arrived
    function automatic seq_state_e next_ld_state(seq_state_e s);
        case (s)
            StLdAm:  return StLdAl;
            StLdAl:  return StLdBm;
            StLdBm:  return StLdBl;
            default: return StExe;
        endcase
    endfunction

    // Timeout counter width: wide enough to hold the larger limit minus one
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Cycle counter shared by the RX inter-byte and ALU-wait timeouts.
// The clearing cycle counts as cycle zero, so the register holds the number
// of cycles elapsed since the last clear; expiry is flagged in the cycle the
// elapsed count equals the limit while no clear is present.
module seq_timeout_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // Restart on clear (next cycle is cycle one), otherwise count while enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= CNT_W'(1);
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A clear in the same cycle always beats expiry
    assign o_expired = i_en & ~i_clr & (r_cnt == i_limit);

endmodule

// File: rtl/core_uart_sequencer.sv
// Transaction sequencer: 5 RX bytes -> one ALU run -> 2 TX bytes, with
// inter-byte and ALU timeouts, overrun flag and completed-operation counter.
module core_uart_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned RX_GAP_MAX   = 50000,
    parameter int unsigned ALU_WAIT_MAX = 64,
    parameter int unsigned OPCNT_W      = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Rx_DV_in,
    input  logic               Tx_Done_in,
    input  logic               c_valid_in,
    output logic               En_out,
    output logic               Load_INS_en_out,
    output logic               Load_MSB_a_en_out,
    output logic               Load_LSB_a_en_out,
    output logic               Load_MSB_b_en_out,
    output logic               Load_LSB_b_en_out,
    output logic               Tx_DV_out,
    output logic               MLSB_SEL_Tx_Byte_out,
    output logic               Busy_out,
    output logic               Err_out,
    output logic [1:0]         Err_code_out,
    output logic               Overrun_out,
    output logic [OPCNT_W-1:0] Op_count_out
);

    localparam int unsigned CNT_W = cnt_width(RX_GAP_MAX, ALU_WAIT_MAX);

    seq_state_e         r_state;
    logic               r_sel;
    logic [1:0]         r_err_code;
    logic               r_overrun;
    logic [OPCNT_W-1:0] r_op_count;

    logic               w_ld_phase;
    logic               w_rx_drop;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_limit;
    logic               w_expired;

    // Phase decode shared by the timeout and flag logic
    always_comb begin
        w_ld_phase = r_state inside {StLdAm, StLdAl, StLdBm, StLdBl};
        w_rx_drop  = Rx_DV_in &
                     (r_state inside {StExe, StWaitC, StSendM, StWaitM, StSendL, StWaitL});
        // RX timeout restarts on every accepted byte, ALU timeout in EXE
        w_cnt_clr  = (Rx_DV_in & (w_ld_phase | (r_state == StIdle))) | (r_state == StExe);
        w_cnt_en   = w_ld_phase | (r_state == StWaitC);
        w_limit    = w_ld_phase ? CNT_W'(RX_GAP_MAX - 1) : CNT_W'(ALU_WAIT_MAX - 1);
    end

    seq_timeout_cnt #(
        .CNT_W(CNT_W)
    ) u_timeout (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .i_limit  (w_limit),
        .o_expired(w_expired)
    );

    // Sequencer FSM with its registered byte-select, error code, overrun and op counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= StIdle;
            r_sel      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_overrun  <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_rx_drop) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (Rx_DV_in) begin
                        r_state   <= StLdAm;
                        r_overrun <= 1'b0;
                    end
                end
                StLdAm, StLdAl, StLdBm, StLdBl: begin
                    if (Rx_DV_in) begin
                        r_state <= next_ld_state(r_state);
                    end else if (w_expired) begin
                        r_state    <= StIdle;
                        r_err_code <= ERR_RXGAP;
                    end
                end
                StExe: r_state <= StWaitC;
                StWaitC: begin
                    if (c_valid_in) begin
                        r_state <= StSendM;
                    end else if (w_expired) begin
                        r_state    <= StIdle;
                        r_err_code <= ERR_ALU;
                    end
                end
                StSendM: r_state <= StWaitM;
                StWaitM: begin
                    if (Tx_Done_in) begin
                        r_state <= StSendL;
                        r_sel   <= 1'b1;
                    end
                end
                StSendL: r_state <= StWaitL;
                StWaitL: begin
                    if (Tx_Done_in) begin
                        r_state    <= StIdle;
                        r_sel      <= 1'b0;
                        r_op_count <= r_op_count + OPCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_sel   <= 1'b0;
                end
            endcase
        end
    end

    // Load enables fire in the same cycle as the byte so the write lands with it
    always_comb begin
        Load_INS_en_out   = (r_state == StIdle) & Rx_DV_in;
        Load_MSB_a_en_out = (r_state == StLdAm) & Rx_DV_in;
        Load_LSB_a_en_out = (r_state == StLdAl) & Rx_DV_in;
        Load_MSB_b_en_out = (r_state == StLdBm) & Rx_DV_in;
        Load_LSB_b_en_out = (r_state == StLdBl) & Rx_DV_in;
        En_out            = (r_state == StExe);
        Tx_DV_out         = (r_state == StSendM) | (r_state == StSendL);
        Busy_out          = (r_state != StIdle);
        // In load states the counter clear is Rx_DV_in, so only c_valid_in needs masking
        Err_out           = w_expired & ~((r_state == StWaitC) & c_valid_in);
        MLSB_SEL_Tx_Byte_out = r_sel;
        Err_code_out      = r_err_code;
        Overrun_out       = r_overrun;
        Op_count_out      = r_op_count;
    end

endmodule
